// File: rtl/copy_stage_n.sv
// Packet COPY stage: captures one packet and emits NCP_eff+1 copies, each with
// destination DEST + k*DEST_STEP and its own LR bit, over a registered Send/Ack handshake.
module copy_stage_n #(
    parameter int HDR_W     = 11,
    parameter int DEST_W    = 7,
    parameter int DATA_W    = 18,
    parameter int MAXC      = 2,
    parameter int CNT_W     = 1,
    parameter int DEST_STEP = 1
) (
    input  logic                                         CLK,
    input  logic                                         MR,
    input  logic                                         Send_in,
    output logic                                         Ack_out,
    input  logic [HDR_W+DEST_W+MAXC+CNT_W+DATA_W-1:0]    PACKET_IN,
    output logic                                         Send_out,
    input  logic                                         Ack_in,
    output logic [HDR_W+DEST_W+1+DATA_W-1:0]             PACKET_OUT,
    output logic                                         COPYING,
    output logic                                         CLAMP_ERR
);

    localparam logic [CNT_W-1:0]  MAX_IDX = CNT_W'(MAXC - 1);
    localparam logic [DEST_W-1:0] STEP    = DEST_W'(DEST_STEP);

    localparam int NCP_LSB  = DATA_W;
    localparam int LRV_LSB  = NCP_LSB + CNT_W;
    localparam int DEST_LSB = LRV_LSB + MAXC;
    localparam int HDR_LSB  = DEST_LSB + DEST_W;

    logic [HDR_W-1:0]  in_hdr;
    logic [DEST_W-1:0] in_dest;
    logic [MAXC-1:0]   in_lrv;
    logic [CNT_W-1:0]  in_ncp;
    logic [DATA_W-1:0] in_data;
    logic              in_clamp;
    logic [CNT_W-1:0]  in_ncp_eff;

    assign in_hdr     = PACKET_IN[HDR_LSB +: HDR_W];
    assign in_dest    = PACKET_IN[DEST_LSB +: DEST_W];
    assign in_lrv     = PACKET_IN[LRV_LSB +: MAXC];
    assign in_ncp     = PACKET_IN[NCP_LSB +: CNT_W];
    assign in_data    = PACKET_IN[DATA_W-1:0];
    assign in_clamp   = in_ncp > MAX_IDX;
    assign in_ncp_eff = in_clamp ? MAX_IDX : in_ncp;

    logic [HDR_W-1:0]  hdr_q,   hdr_d;
    logic [DEST_W-1:0] dest_q,  dest_d;
    logic [MAXC-1:0]   lrv_q,   lrv_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              full_q,  full_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  last_q,  last_d;
    logic              clamp_q, clamp_d;

    logic              at_last;
    logic              in_fire;
    logic              out_fire;
    logic [MAXC-1:0]   lr_hit;
    logic              lr_k;
    logic [DEST_W-1:0] dest_k;

    // One-hot select of LRV[IDX]; indices beyond LAST are never reached.
    genvar gi;
    generate
        for (gi = 0; gi < MAXC; gi++) begin : g_lr_sel
            assign lr_hit[gi] = lrv_q[gi] & (idx_q == CNT_W'(gi));
        end
    endgenerate

    assign lr_k     = |lr_hit;
    assign dest_k   = dest_q + DEST_W'(idx_q) * STEP;
    assign at_last  = (idx_q == last_q);
    assign out_fire = full_q & Ack_in;
    // Retiring the last copy frees DL this edge, so a new packet may enter alongside it.
    assign Ack_out  = ~MR & (~full_q | (at_last & Ack_in));
    assign in_fire  = Send_in & Ack_out;

    assign Send_out   = full_q;
    assign PACKET_OUT = {hdr_q, dest_k, lr_k, data_q};
    assign COPYING    = full_q & ~at_last;
    assign CLAMP_ERR  = clamp_q;

    always_comb begin
        hdr_d   = hdr_q;
        dest_d  = dest_q;
        lrv_d   = lrv_q;
        data_d  = data_q;
        full_d  = full_q;
        idx_d   = idx_q;
        last_d  = last_q;
        clamp_d = clamp_q;

        if (out_fire) begin
            if (at_last) begin
                full_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (in_fire) begin
            hdr_d  = in_hdr;
            dest_d = in_dest;
            lrv_d  = in_lrv;
            data_d = in_data;
            full_d = 1'b1;
            idx_d  = '0;
            last_d = in_ncp_eff;
            if (in_clamp) begin
                clamp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            hdr_q   <= '0;
            dest_q  <= '0;
            lrv_q   <= '0;
            data_q  <= '0;
            full_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            clamp_q <= 1'b0;
        end else begin
            hdr_q   <= hdr_d;
            dest_q  <= dest_d;
            lrv_q   <= lrv_d;
            data_q  <= data_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            clamp_q <= clamp_d;
        end
    end

endmodule

// File: tb/tb_copy_stage_n.sv
// Scoreboard bench for copy_stage_n: a default instance (A) and a MAXC=4, CNT_W=3,
// DEST_STEP=2 instance (B) share clock, reset and downstream ready.
module tb_copy_stage_n;

    logic        clk = 1'b0;
    logic        mr;
    logic        ack_in;

    logic        send_in_a, ack_out_a, send_out_a, copying_a, clamp_a;
    logic [38:0] packet_in_a;
    logic [36:0] packet_out_a;

    logic        send_in_b, ack_out_b, send_out_b, copying_b, clamp_b;
    logic [42:0] packet_in_b;
    logic [36:0] packet_out_b;

    // Expected entry: {Ack_out, COPYING, PACKET_OUT}
    logic [38:0] q_a[$];
    logic [38:0] q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    copy_stage_n dut_a (
        .CLK(clk), .MR(mr),
        .Send_in(send_in_a), .Ack_out(ack_out_a), .PACKET_IN(packet_in_a),
        .Send_out(send_out_a), .Ack_in(ack_in), .PACKET_OUT(packet_out_a),
        .COPYING(copying_a), .CLAMP_ERR(clamp_a)
    );

    copy_stage_n #(.MAXC(4), .CNT_W(3), .DEST_STEP(2)) dut_b (
        .CLK(clk), .MR(mr),
        .Send_in(send_in_b), .Ack_out(ack_out_b), .PACKET_IN(packet_in_b),
        .Send_out(send_out_b), .Ack_in(ack_in), .PACKET_OUT(packet_out_b),
        .COPYING(copying_b), .CLAMP_ERR(clamp_b)
    );

    function automatic logic [38:0] pin_a(logic [10:0] h, logic [6:0] d, logic [1:0] lrv,
                                          logic n, logic [17:0] dat);
        return {h, d, lrv, n, dat};
    endfunction

    function automatic logic [42:0] pin_b(logic [10:0] h, logic [6:0] d, logic [3:0] lrv,
                                          logic [2:0] n, logic [17:0] dat);
        return {h, d, lrv, n, dat};
    endfunction

    function automatic logic [38:0] ex(logic ack, logic cp, logic [10:0] h, logic [6:0] d,
                                       logic lr, logic [17:0] dat);
        return {ack, cp, h, d, lr, dat};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic send_a(input logic [38:0] p);
        int n = 0;
        send_in_a   = 1'b1;
        packet_in_a = p;
        @(negedge clk);
        while (!ack_out_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack_out_a) timeout_fail("a_send");
        @(posedge clk);
        #1;
        send_in_a = 1'b0;
    endtask

    task automatic send_b(input logic [42:0] p);
        int n = 0;
        send_in_b   = 1'b1;
        packet_in_b = p;
        @(negedge clk);
        while (!ack_out_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack_out_b) timeout_fail("b_send");
        @(posedge clk);
        #1;
        send_in_b = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) timeout_fail("drain");
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        mr = 1'b1; ack_in = 1'b0;
        send_in_a = 1'b0; packet_in_a = '0;
        send_in_b = 1'b0; packet_in_b = '0;

        // Monitor: compares every downstream transfer against the scoreboard head.
        fork
            forever begin
                @(negedge clk);
                if (!mr && ack_in && send_out_a) begin
                    $display("emit A: pkt=%h copying=%b ack_out=%b", packet_out_a, copying_a, ack_out_a);
                    if (q_a.size() == 0) check("a_unexpected_emit", {ack_out_a, copying_a, packet_out_a}, 64'h0);
                    else check("a_emit", {ack_out_a, copying_a, packet_out_a}, q_a.pop_front());
                end
                if (!mr && ack_in && send_out_b) begin
                    $display("emit B: pkt=%h copying=%b ack_out=%b", packet_out_b, copying_b, ack_out_b);
                    if (q_b.size() == 0) check("b_unexpected_emit", {ack_out_b, copying_b, packet_out_b}, 64'h0);
                    else check("b_emit", {ack_out_b, copying_b, packet_out_b}, q_b.pop_front());
                end
            end
        join_none

        @(posedge clk); #1;
        check("rst_send_out", send_out_a, 0);
        check("rst_ack_out", ack_out_a, 0);
        check("rst_packet_out", packet_out_a, 0);
        check("rst_clamp", clamp_b, 0);
        @(posedge clk); #1;
        mr = 1'b0;
        #1;
        check("rel_ack_out", ack_out_a, 1);
        ack_in = 1'b1;

        // Single-emission packets stream back to back
        q_a.push_back(ex(1, 0, 11'h101, 7'd5, 0, 18'h00011));
        q_a.push_back(ex(1, 0, 11'h102, 7'd9, 0, 18'h00022));
        send_a(pin_a(11'h101, 7'd5, 2'b10, 1'b0, 18'h00011));
        send_a(pin_a(11'h102, 7'd9, 2'b10, 1'b0, 18'h00022));
        drain();

        // Two copies with destination wrap
        q_a.push_back(ex(0, 1, 11'h5A3, 7'h7F, 0, 18'h2A5A5));
        q_a.push_back(ex(1, 0, 11'h5A3, 7'h00, 1, 18'h2A5A5));
        send_a(pin_a(11'h5A3, 7'h7F, 2'b10, 1'b1, 18'h2A5A5));
        drain();

        // Backpressure: hold first copy for 3 cycles
        ack_in = 1'b0;
        q_a.push_back(ex(0, 1, 11'h001, 7'd3, 1, 18'h01234));
        q_a.push_back(ex(1, 0, 11'h001, 7'd4, 0, 18'h01234));
        send_a(pin_a(11'h001, 7'd3, 2'b01, 1'b1, 18'h01234));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_send_out", send_out_a, 1);
            check("bp_packet_out", packet_out_a, {11'h001, 7'd3, 1'b1, 18'h01234});
            check("bp_ack_out", ack_out_a, 0);
        end
        @(posedge clk); #1;
        ack_in = 1'b1;
        drain();

        // Clamp on B: NCP=6 limited to 4 emissions
        check("clamp_before", clamp_b, 0);
        q_b.push_back(ex(0, 1, 11'h2BC, 7'd10, 1, 18'h3C0F0));
        q_b.push_back(ex(0, 1, 11'h2BC, 7'd12, 0, 18'h3C0F0));
        q_b.push_back(ex(0, 1, 11'h2BC, 7'd14, 1, 18'h3C0F0));
        q_b.push_back(ex(1, 0, 11'h2BC, 7'd16, 0, 18'h3C0F0));
        send_b(pin_b(11'h2BC, 7'd10, 4'b0101, 3'd6, 18'h3C0F0));
        check("clamp_after_capture", clamp_b, 1);
        drain();
        check("clamp_sticky", clamp_b, 1);

        // Reset mid-stream with A holding a packet
        ack_in = 1'b0;
        send_a(pin_a(11'h7FF, 7'd40, 2'b11, 1'b1, 18'h3FFFF));
        check("pre_mr_send_out", send_out_a, 1);
        mr = 1'b1;
        q_a.delete();
        #1;
        check("mr_send_out", send_out_a, 0);
        check("mr_ack_out", ack_out_a, 0);
        check("mr_packet_out", packet_out_a, 0);
        check("mr_clamp", clamp_b, 0);
        check("mr_ack_out_b", ack_out_b, 0);
        @(posedge clk); @(posedge clk); #1;
        mr = 1'b0;
        #1;
        check("mr_rel_ack_out", ack_out_a, 1);
        check("mr_rel_send_out", send_out_a, 0);
        ack_in = 1'b1;

        // Reset during emission 2 of 4 on B, then a fresh single packet
        q_b.push_back(ex(0, 1, 11'h0F0, 7'd20, 0, 18'h15555));
        q_b.push_back(ex(0, 1, 11'h0F0, 7'd22, 1, 18'h15555));
        q_b.push_back(ex(0, 1, 11'h0F0, 7'd24, 0, 18'h15555));
        q_b.push_back(ex(1, 0, 11'h0F0, 7'd26, 1, 18'h15555));
        send_b(pin_b(11'h0F0, 7'd20, 4'b1010, 3'd3, 18'h15555));
        @(posedge clk); #1;
        check("b_e2_before_mr", packet_out_b, {11'h0F0, 7'd22, 1'b1, 18'h15555});
        mr = 1'b1;
        q_b.delete();
        #1;
        check("b_mr_send_out", send_out_b, 0);
        check("b_mr_packet_out", packet_out_b, 0);
        check("b_mr_copying", copying_b, 0);
        @(posedge clk); #1;
        mr = 1'b0;
        q_b.push_back(ex(1, 0, 11'h3A1, 7'd33, 0, 18'h0BEEF));
        send_b(pin_b(11'h3A1, 7'd33, 4'b1110, 3'd0, 18'h0BEEF));
        drain();
        check("b_final_idle", send_out_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
